// File: rtl/led_frame_pkg.sv
// Shared definitions for the LED frame buffer and the WS2812b driver.
//   COLOR_W    : packed {R,G,B} word width
//   wr_state_t : host write FSM encoding
//   log2       : address width helper (never below 1)
package led_frame_pkg;

    localparam int COLOR_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RED   = 2'd1,
        ST_GREEN = 2'd2,
        ST_BLUE  = 2'd3
    } wr_state_t;

    // Ceiling log2. Returns at least 1 so a single-LED strip still has an address bit.
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/led_frame_buffer_if.sv
// Host byte stream, driver read handshake and frame status of the frame buffer.
//   slave  : the frame buffer side
//   master : the host/driver side (stimulus in a bench)
interface led_frame_buffer_if #(
    parameter int LED_ADDRESS_WIDTH = 2
);
    logic [7:0]                   byte_in;
    logic                         byte_valid;
    logic                         frame_start;
    logic                         data_request;
    logic [LED_ADDRESS_WIDTH-1:0] address;
    logic [7:0]                   red_out;
    logic [7:0]                   green_out;
    logic [7:0]                   blue_out;
    logic                         frame_pending;
    logic                         frame_swapped;
    logic                         frame_dropped;

    modport slave (
        input  byte_in, byte_valid, frame_start, data_request, address,
        output red_out, green_out, blue_out, frame_pending, frame_swapped, frame_dropped
    );

    modport master (
        output byte_in, byte_valid, frame_start, data_request, address,
        input  red_out, green_out, blue_out, frame_pending, frame_swapped, frame_dropped
    );
endinterface

// File: rtl/led_color_ram.sv
// Colour store: one write port, one synchronous read port, no reset.
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port; rdata holds until the next re
module led_color_ram
    import led_frame_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [COLOR_W-1:0] rdata
);
    logic [COLOR_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered RGB frame store feeding the WS2812b driver.
//   clk, reset : system clock, async active-high reset
//   bus        : host bytes in, driver request/address in, colours and frame status out
// The host fills the back bank; the driver reads the front bank. Banks swap only
// when the driver requests address 0 with a complete frame pending.
module led_frame_buffer
    import led_frame_pkg::*;
#(
    parameter int NUM_LEDS          = 4,
    parameter int LED_ADDRESS_WIDTH = log2(NUM_LEDS)
) (
    input  logic clk,
    input  logic reset,
    led_frame_buffer_if.slave bus
);
    localparam int AW = LED_ADDRESS_WIDTH;
    localparam logic [AW-1:0] LAST_LED = AW'(NUM_LEDS - 1);

    wr_state_t    state;
    logic [AW-1:0] idx;
    logic [7:0]   r_hold, g_hold;
    logic         front, front_valid, pending, swapped, dropped;
    logic         rd_ok_q;

    logic               swap, front_next, in_range, we, re;
    logic [AW:0]        waddr, raddr;
    logic [COLOR_W-1:0] wdata, rdata;

    // Swap decision uses the pre-update pending flag, so a frame finishing
    // this cycle waits for the next driver frame start.
    assign swap       = bus.data_request && (bus.address == '0) && pending;
    assign front_next = front ^ swap;
    assign in_range   = int'(bus.address) < NUM_LEDS;

    // A frame_start byte always restarts the frame, so it can never be a blue byte.
    assign we    = bus.byte_valid && !bus.frame_start && (state == ST_BLUE);
    assign waddr = {~front, idx};
    assign wdata = {r_hold, g_hold, bus.byte_in};
    assign re    = bus.data_request && in_range;
    assign raddr = {front_next, bus.address};

    led_color_ram #(.ADDR_W(AW + 1)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            r_hold      <= '0;
            g_hold      <= '0;
            front       <= 1'b0;
            front_valid <= 1'b0;
            pending     <= 1'b0;
            swapped     <= 1'b0;
            dropped     <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            swapped     <= swap;
            dropped     <= 1'b0;
            front       <= front_next;
            front_valid <= front_valid | swap;
            if (swap) pending <= 1'b0;

            // Memory is undefined until a complete frame reaches the front bank,
            // so reads before that (and out-of-range reads) return black.
            if (bus.data_request) rd_ok_q <= in_range && (front_valid || swap);

            if (bus.byte_valid && bus.frame_start) begin
                r_hold  <= bus.byte_in;
                idx     <= '0;
                state   <= ST_GREEN;
                pending <= 1'b0;
                dropped <= pending && !swap;
            end else if (bus.byte_valid) begin
                case (state)
                    ST_RED: begin
                        r_hold <= bus.byte_in;
                        state  <= ST_GREEN;
                    end
                    ST_GREEN: begin
                        g_hold <= bus.byte_in;
                        state  <= ST_BLUE;
                    end
                    ST_BLUE: begin
                        if (idx == LAST_LED) begin
                            pending <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_RED;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.red_out       = rd_ok_q ? rdata[23:16] : 8'd0;
    assign bus.green_out     = rd_ok_q ? rdata[15:8]  : 8'd0;
    assign bus.blue_out      = rd_ok_q ? rdata[7:0]   : 8'd0;
    assign bus.frame_pending = pending;
    assign bus.frame_swapped = swapped;
    assign bus.frame_dropped = dropped;
endmodule

// File: tb/tb_led_frame_buffer.sv
module tb_led_frame_buffer;
    typedef logic [7:0] frame_t [12];
    typedef struct {
        logic [23:0] rgb;
        logic        sw;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic req_d;
    exp_t q[$];

    led_frame_buffer_if #(.LED_ADDRESS_WIDTH(2)) bus ();

    led_frame_buffer #(.NUM_LEDS(4), .LED_ADDRESS_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: one cycle after each request, compare against the scoreboard.
    always @(posedge clk) req_d <= bus.data_request;

    always @(negedge clk) begin
        exp_t e;
        if (req_d === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL read: output with no expected entry");
            end else begin
                e = q.pop_front();
                chk("read_rgb", {bus.red_out, bus.green_out, bus.blue_out}, e.rgb);
                chk("swap_pulse", {23'd0, bus.frame_swapped}, {23'd0, e.sw});
            end
        end
    end

    function automatic frame_t mk(input int base);
        frame_t f;
        for (int i = 0; i < 12; i++) f[i] = 8'(base + i);
        return f;
    endfunction

    function automatic logic [23:0] led(input frame_t f, input int i);
        return {f[3*i], f[3*i+1], f[3*i+2]};
    endfunction

    task automatic put_byte(input logic [7:0] b, input logic fs);
        bus.byte_in     = b;
        bus.byte_valid  = 1'b1;
        bus.frame_start = fs;
    endtask

    task automatic put_req(input logic [1:0] a, input logic [23:0] rgb, input logic sw);
        exp_t e;
        e.rgb = rgb;
        e.sw  = sw;
        q.push_back(e);
        bus.data_request = 1'b1;
        bus.address      = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.byte_valid   = 1'b0;
        bus.frame_start  = 1'b0;
        bus.data_request = 1'b0;
        bus.address      = '0;
        bus.byte_in      = '0;
    endtask

    task automatic req(input logic [1:0] a, input logic [23:0] rgb, input logic sw);
        put_req(a, rgb, sw);
        step();
    endtask

    task automatic send(input frame_t f, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            put_byte(f[i], i == 0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        frame_t f1, f2, f3, f4, f5, f6, f7, f8;
        f1 = '{8'd10, 8'd20, 8'd30, 8'd11, 8'd21, 8'd31, 8'd12, 8'd22, 8'd32, 8'd40, 8'd50, 8'd60};
        f2 = mk(100); f3 = mk(200); f4 = mk(1); f5 = mk(30);
        f6 = mk(60);  f7 = mk(150); f8 = mk(80);
        n_checks = 0;
        n_pass   = 0;
        bus.byte_in = '0; bus.byte_valid = 1'b0; bus.frame_start = 1'b0;
        bus.data_request = 1'b0; bus.address = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();
        chk("reset_pending", {23'd0, bus.frame_pending}, 24'd0);
        chk("reset_dropped", {23'd0, bus.frame_dropped}, 24'd0);
        chk("reset_swapped", {23'd0, bus.frame_swapped}, 24'd0);
        chk("reset_rgb", {bus.red_out, bus.green_out, bus.blue_out}, 24'd0);

        // No frame yet: black.
        req(0, 24'd0, 1'b0);

        // Stray bytes with no frame_start are ignored.
        for (int i = 0; i < 3; i++) begin put_byte(8'd5, 1'b0); step(); end
        chk("stray_pending", {23'd0, bus.frame_pending}, 24'd0);

        // Frame 1, then 3 extra bytes that must be ignored.
        send(f1, 0, 11);
        chk("f1_pending", {23'd0, bus.frame_pending}, 24'd1);
        for (int i = 0; i < 3; i++) begin put_byte(8'(99 - i), 1'b0); step(); end
        chk("extra_pending", {23'd0, bus.frame_pending}, 24'd1);
        req(0, 24'h0a141e, 1'b1);
        chk("swap_clears_pending", {23'd0, bus.frame_pending}, 24'd0);
        req(3, 24'h28323c, 1'b0);
        req(1, led(f1, 1), 1'b0);

        // Bytes in IDLE after a completed frame change nothing.
        for (int i = 0; i < 3; i++) begin put_byte(8'd77, 1'b0); step(); end
        chk("idle_pending", {23'd0, bus.frame_pending}, 24'd0);
        req(0, led(f1, 0), 1'b0);

        // Frame 2 completes mid driver frame, in the same cycle as an address-0 request.
        req(2, led(f1, 2), 1'b0);
        send(f2, 0, 10);
        put_byte(f2[11], 1'b0);
        put_req(0, led(f1, 0), 1'b0);
        step();
        chk("f2_pending", {23'd0, bus.frame_pending}, 24'd1);
        req(3, led(f1, 3), 1'b0);
        req(0, led(f2, 0), 1'b1);
        req(3, led(f2, 3), 1'b0);

        // Pending frame 3 dropped by frame 4's start.
        send(f3, 0, 11);
        chk("f3_pending", {23'd0, bus.frame_pending}, 24'd1);
        put_byte(f4[0], 1'b1);
        step();
        chk("drop_pulse", {23'd0, bus.frame_dropped}, 24'd1);
        chk("drop_pending", {23'd0, bus.frame_pending}, 24'd0);
        send(f4, 1, 11);
        chk("drop_pulse_end", {23'd0, bus.frame_dropped}, 24'd0);
        req(0, led(f4, 0), 1'b1);
        req(3, led(f4, 3), 1'b0);
        req(2, led(f4, 2), 1'b0);

        // frame_start coincident with swap: swap wins, no drop, new frame goes to old front.
        send(f5, 0, 11);
        put_byte(f6[0], 1'b1);
        put_req(0, led(f5, 0), 1'b1);
        step();
        chk("fs_swap_no_drop", {23'd0, bus.frame_dropped}, 24'd0);
        chk("fs_swap_pending", {23'd0, bus.frame_pending}, 24'd0);
        send(f6, 1, 11);
        chk("f6_pending", {23'd0, bus.frame_pending}, 24'd1);
        req(0, led(f6, 0), 1'b1);
        req(1, led(f6, 1), 1'b0);

        // Asynchronous reset mid-frame.
        send(f7, 0, 4);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_rgb", {bus.red_out, bus.green_out, bus.blue_out}, 24'd0);
        chk("async_reset_pending", {23'd0, bus.frame_pending}, 24'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        req(0, 24'd0, 1'b0);
        send(f8, 0, 11);
        req(0, led(f8, 0), 1'b1);
        req(3, led(f8, 3), 1'b0);

        step();
        step();
        chk("scoreboard_drained", 24'(q.size()), 24'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
